// File: rtl/rx_block_lock_ctrl.sv
// rx_block_lock_ctrl: two-lane 64b/66b (Gen2) and 128b/132b (Gen3) block-lock
// controller. Each lane hunts for sync-header alignment, requests bit slips
// from its deserializer, and holds lock until too many header errors appear
// within a window. Gen4 lanes skip header checking entirely. The decoder
// enable is asserted only while both lanes are locked.
module rx_block_lock_ctrl #(
  parameter int LOCK_CNT   = 64,  // consecutive good headers needed to lock
  parameter int WIN_LEN    = 64,  // strobes per error-counting window in LOCK
  parameter int UNLOCK_BAD = 16,  // bad headers per window that drop lock
  parameter int SLIP_GAP   = 2    // strobes skipped after a slip
) (
  input  logic       enc_clk_i,
  input  logic       rst_i,
  input  logic       rx_en_i,
  input  logic [1:0] gen_speed_i,
  input  logic       hdr_valid_i,
  input  logic [3:0] sync_hdr_0_i,
  input  logic [3:0] sync_hdr_1_i,
  output logic       slip_0_o,
  output logic       slip_1_o,
  output logic [1:0] block_lock_o,
  output logic       enable_dec_o,
  output logic       lock_lost_o,
  output logic [7:0] err_cnt_o
);

  localparam logic [7:0] LOCK_CNT_C   = 8'(LOCK_CNT);
  localparam logic [7:0] WIN_LEN_C    = 8'(WIN_LEN);
  localparam logic [7:0] UNLOCK_BAD_C = 8'(UNLOCK_BAD);
  localparam logic [3:0] SLIP_GAP_C   = 4'(SLIP_GAP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HUNT = 2'd1,
    ST_SLIP = 2'd2,
    ST_LOCK = 2'd3
  } lane_state_e;

  // Speed seen on the previous cycle; any change aborts both lanes.
  logic [1:0] gen_q;
  logic       abort;

  logic [3:0] hdr_arr [2];

  // Per-lane results gathered for the shared output registers.
  logic [1:0] lock_d_vec;
  logic [1:0] slip_d_vec;
  logic [1:0] leave_vec;
  logic [1:0] err_inc_vec;

  logic [1:0] lock_q;
  logic [1:0] slip_q;
  logic       en_q;
  logic       lost_q;
  logic [7:0] err_q;
  logic [7:0] err_d;
  logic [8:0] err_sum;

  assign abort      = !rx_en_i || (gen_speed_i != gen_q);
  assign hdr_arr[0] = sync_hdr_0_i;
  assign hdr_arr[1] = sync_hdr_1_i;

  // Sync-header legality for the current speed; Gen4 accepts anything.
  function automatic logic hdr_ok(input logic [1:0] gen, input logic [3:0] hdr);
    logic ok;
    ok = 1'b1;
    case (gen)
      2'b10:   ok = (hdr[1:0] == 2'b01) || (hdr[1:0] == 2'b10);
      2'b01:   ok = (hdr == 4'b0101) || (hdr == 4'b1010);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    lane_state_e state_q, state_d;
    logic [7:0]  good_q, good_d;
    logic [7:0]  blk_q, blk_d;
    logic [7:0]  bad_q, bad_d;
    logic [3:0]  gap_q, gap_d;
    logic        slip_d;
    logic        leave_lock;
    logic        err_inc;
    logic        hdr_good;

    assign hdr_good = hdr_ok(gen_speed_i, hdr_arr[gi]);

    // Lane next-state: abort first, then per-state header strobe handling.
    always_comb begin
      state_d    = state_q;
      good_d     = good_q;
      blk_d      = blk_q;
      bad_d      = bad_q;
      gap_d      = gap_q;
      slip_d     = 1'b0;
      leave_lock = 1'b0;
      err_inc    = 1'b0;
      if (abort) begin
        state_d    = ST_IDLE;
        good_d     = 8'd0;
        blk_d      = 8'd0;
        bad_d      = 8'd0;
        gap_d      = 4'd0;
        leave_lock = (state_q == ST_LOCK);
      end else begin
        case (state_q)
          ST_IDLE: begin
            if ((gen_speed_i == 2'b01) || (gen_speed_i == 2'b10)) begin
              state_d = ST_HUNT;
              good_d  = 8'd0;
            end else if ((gen_speed_i == 2'b00) && hdr_valid_i) begin
              state_d = ST_LOCK;
              blk_d   = 8'd0;
              bad_d   = 8'd0;
            end
          end
          ST_HUNT: begin
            if (hdr_valid_i) begin
              if (hdr_good) begin
                good_d = good_q + 8'd1;
                if (good_d == LOCK_CNT_C) begin
                  state_d = ST_LOCK;
                  blk_d   = 8'd0;
                  bad_d   = 8'd0;
                end
              end else begin
                slip_d  = 1'b1;
                good_d  = 8'd0;
                gap_d   = 4'd0;
                state_d = ST_SLIP;
              end
            end
          end
          ST_SLIP: begin
            if (hdr_valid_i) begin
              gap_d = gap_q + 4'd1;
              if (gap_d == SLIP_GAP_C) begin
                state_d = ST_HUNT;
                good_d  = 8'd0;
                gap_d   = 4'd0;
              end
            end
          end
          ST_LOCK: begin
            if (hdr_valid_i) begin
              blk_d = blk_q + 8'd1;
              if (!hdr_good) begin
                bad_d   = bad_q + 8'd1;
                err_inc = 1'b1;
              end
              // Unlock outranks the window rollover on the same strobe.
              if (!hdr_good && (bad_d == UNLOCK_BAD_C)) begin
                state_d    = ST_HUNT;
                good_d     = 8'd0;
                blk_d      = 8'd0;
                bad_d      = 8'd0;
                leave_lock = 1'b1;
              end else if (blk_d == WIN_LEN_C) begin
                blk_d = 8'd0;
                bad_d = 8'd0;
              end
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    // Lane state and counter registers.
    always_ff @(posedge enc_clk_i) begin
      if (rst_i) begin
        state_q <= ST_IDLE;
        good_q  <= 8'd0;
        blk_q   <= 8'd0;
        bad_q   <= 8'd0;
        gap_q   <= 4'd0;
      end else begin
        state_q <= state_d;
        good_q  <= good_d;
        blk_q   <= blk_d;
        bad_q   <= bad_d;
        gap_q   <= gap_d;
      end
    end

    assign lock_d_vec[gi]  = (state_d == ST_LOCK);
    assign slip_d_vec[gi]  = slip_d;
    assign leave_vec[gi]   = leave_lock;
    assign err_inc_vec[gi] = err_inc;
  end

  // Shared error count: both lanes may add in one strobe; saturate at 255.
  always_comb begin
    err_sum = {1'b0, err_q} + 9'(err_inc_vec[0]) + 9'(err_inc_vec[1]);
    err_d   = err_q;
    if (!rx_en_i) begin
      err_d = 8'd0;
    end else if (err_sum > 9'd255) begin
      err_d = 8'hFF;
    end else begin
      err_d = err_sum[7:0];
    end
  end

  // Output registers; enable_dec needs both lanes locked now and next.
  always_ff @(posedge enc_clk_i) begin
    if (rst_i) begin
      gen_q  <= 2'b00;
      lock_q <= 2'b00;
      slip_q <= 2'b00;
      en_q   <= 1'b0;
      lost_q <= 1'b0;
      err_q  <= 8'd0;
    end else begin
      gen_q  <= gen_speed_i;
      lock_q <= lock_d_vec;
      slip_q <= slip_d_vec;
      en_q   <= (&lock_q) & (&lock_d_vec);
      lost_q <= |leave_vec;
      err_q  <= err_d;
    end
  end

  assign slip_0_o     = slip_q[0];
  assign slip_1_o     = slip_q[1];
  assign block_lock_o = lock_q;
  assign enable_dec_o = en_q;
  assign lock_lost_o  = lost_q;
  assign err_cnt_o    = err_q;

endmodule

// File: doc/rx_block_lock_ctrl.md
Name: rx_block_lock_ctrl

Overview:
- Per-lane sync-header block-lock controller for the two-lane receive path. It sits ahead of the lane decoder.
- Hunts for 64b/66b (Gen2) or 128b/132b (Gen3) block alignment on lane 0 and lane 1 independently, issuing bit-slip requests to the deserializers.
- Declares lock after a run of valid sync headers and drops lock on excessive header errors.
- Drives enable_dec to the decoder only while both lanes are locked.

Parameters:
- LOCK_CNT, 64: consecutive valid headers required to declare lock (range 2..255).
- WIN_LEN, 64: header-strobe window length while locked (range 2..255).
- UNLOCK_BAD, 16: invalid headers within one window that force loss of lock (range 1..WIN_LEN).
- SLIP_GAP, 2: header strobes ignored after a slip before hunting resumes (range 1..15).

Ports:
- enc_clk  in  1  receive encoded-domain clock; sole clock.
- rst  in  1  synchronous, active-high reset.
- rx_en  in  1  receive path enabled; low returns both lanes to IDLE.
- gen_speed  in  2  00=Gen4, 01=Gen3, 10=Gen2, 11=invalid.
- hdr_valid  in  1  one-cycle strobe: new block header present on both lanes.
- sync_hdr_0  in  4  lane 0 header. Gen2 uses [1:0]; Gen3 uses [3:0].
- sync_hdr_1  in  4  lane 1 header, same layout.
- slip_0, slip_1  out  1  one-cycle slip request to the lane deserializer.
- block_lock  out  2  per-lane lock status, bit i = lane i.
- enable_dec  out  1  decoder enable.
- lock_lost  out  1  one-cycle pulse when either lane leaves LOCK.
- err_cnt  out  8  saturating count of invalid headers seen while locked, both lanes.

Behaviour:
- Clock and reset: enc_clk is the only clock; rst is synchronous and active-high.
- Reset values: all outputs 0; both lane FSMs in IDLE; all counters 0.
- Valid header definition:
  - Gen2: [1:0] is 01 or 10.
  - Gen3: [3:0] is 0101 or 1010.
  - Gen4: no header check.
- Per-lane FSM states: IDLE, HUNT, SLIP, LOCK. Both lanes run identical, independent FSMs.
- IDLE:
  - If rx_en=1 and gen_speed is 01 or 10 -> HUNT, good_cnt=0.
  - If rx_en=1 and gen_speed=00 -> LOCK on the next hdr_valid.
  - If gen_speed=11 -> remain in IDLE.
- HUNT, on each hdr_valid:
  - Valid header: good_cnt++. When the count reaches LOCK_CNT -> LOCK, with blk_cnt=0 and bad_cnt=0.
  - Invalid header: assert slip_i for exactly one cycle (the cycle after the strobe), set good_cnt=0, -> SLIP.
- SLIP: count hdr_valid strobes; after SLIP_GAP strobes -> HUNT. Headers in this state are not evaluated.
- LOCK, on each hdr_valid:
  - blk_cnt++ on every strobe.
  - On an invalid header, bad_cnt++ and err_cnt++ (err_cnt saturates at 255).
  - If bad_cnt reaches UNLOCK_BAD -> HUNT, good_cnt=0, pulse lock_lost.
  - When blk_cnt reaches WIN_LEN, clear both blk_cnt and bad_cnt.
  - Gen4 lanes never leave LOCK through header errors.
- Abort conditions, all lanes, any state:
  - rx_en=0, or gen_speed differs from its value registered on the previous cycle -> IDLE on the next cycle.
  - The lane's counters clear.
  - lock_lost pulses if any lane was in LOCK.
  - err_cnt clears only on rst or rx_en=0.
- Outputs:
  - block_lock[i] = (state_i == LOCK), registered.
  - enable_dec is registered from block_lock[0] & block_lock[1], so it rises one cycle after the later lane locks.
  - enable_dec falls in the same cycle that block_lock drops.
- Simultaneous events:
  - An abort takes priority over any hdr_valid handling in the same cycle.
  - In LOCK, if the unlock threshold and the window end coincide, unlock wins.
  - Reaching the lock count and seeing an invalid header cannot coincide; the invalid header is evaluated first.
  - slip_0 and slip_1 may assert in the same cycle.
  - lock_lost is a single pulse even if both lanes unlock together.
- Latency: header strobe -> slip_i, block_lock, lock_lost, or err_cnt update is 1 cycle.
- Counter widths: 8 bits for good_cnt, blk_cnt and bad_cnt; 4 bits for the slip counter. No wrap beyond the parameter range.

Test Plan:
- Gen2 lock, default parameters: rx_en=1, gen_speed=10, 64 strobes with headers 01/10 alternating on both lanes -> block_lock=11 after the 64th strobe plus 1 cycle; enable_dec=1 one cycle later; slip_0=slip_1=0 throughout.
- Gen3 hunt with slip: lane 1 header 0000 on the 3rd strobe, then valid 0101 -> slip_1 one-cycle pulse; lane 1 ignores 2 strobes, then needs 64 new valid headers; block_lock goes 01 then 11; enable_dec follows lane 1.
- Loss of lock: locked Gen2, 16 invalid headers (00) on lane 0 within 64 strobes -> lock_lost pulse; block_lock=10; enable_dec=0; err_cnt=16. With 15 invalid per window over 3 windows -> stays locked, err_cnt=45.
- Gen4 and invalid speed: gen_speed=00, first strobe -> block_lock=11 regardless of header; gen_speed=11 -> both lanes stay IDLE, enable_dec=0.
- Abort mid-operation: locked at Gen3, gen_speed changes to 10 in the same cycle as hdr_valid -> next cycle both lanes IDLE, lock_lost one pulse, enable_dec=0, err_cnt retained; rx_en=0 -> err_cnt=0.
- Reset and saturation: 300 invalid headers while locked with UNLOCK_BAD=WIN_LEN=255 -> err_cnt holds 255; assert rst mid-stream -> next cycle all outputs 0.
